// File: rtl/mul_div_unit_pkg.sv
// Shared execute-stage types: multiply/divide opcodes and the ALU status word.
// Classification helpers let the unit and its fix-up stage agree on op groups.
package ablomm_cpu;

    typedef enum logic [2:0] {
        MUL   = 3'd0,
        MULHU = 3'd1,
        MULHS = 3'd2,
        DIVU  = 3'd3,
        REMU  = 3'd4,
        DIVS  = 3'd5,
        REMS  = 3'd6
    } muldiv_op_e;

    typedef struct packed {
        logic negative;
        logic zero;
        logic carry;
        logic overflow;
    } status_t;

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == DIVU) || (op == REMU) || (op == DIVS) || (op == REMS);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_e op);
        return (op == MULHS) || (op == DIVS) || (op == REMS);
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Fix-up stage of mul_div_unit: sign correction, result select and status flags.
// Purely combinational; its outputs are registered by the parent.
module mul_div_sign_fix
    import ablomm_cpu::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_op_e         i_op,
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic [WIDTH-1:0]   i_quo,
    input  logic [WIDTH-1:0]   i_rem,
    input  logic               i_sign_q,
    input  logic               i_sign_r,
    input  logic               i_div0,
    input  logic               i_ovf_min,
    output logic [WIDTH-1:0]   o_result,
    output status_t            o_status
);

    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quo_neg;
    logic [WIDTH-1:0]   w_rem_neg;

    assign w_prod_neg = -i_prod;
    assign w_quo_neg  = -i_quo;
    assign w_rem_neg  = -i_rem;

    // On divide-by-zero the remainder register holds the raw dividend.
    always_comb begin
        o_result = i_prod[WIDTH-1:0];
        case (i_op)
            MUL:     o_result = i_prod[WIDTH-1:0];
            MULHU:   o_result = i_prod[2*WIDTH-1:WIDTH];
            MULHS:   o_result = i_sign_q ? w_prod_neg[2*WIDTH-1:WIDTH] : i_prod[2*WIDTH-1:WIDTH];
            DIVU:    o_result = i_div0 ? '1 : i_quo;
            REMU:    o_result = i_rem;
            DIVS:    o_result = i_div0 ? '1 : (i_sign_q ? w_quo_neg : i_quo);
            REMS:    o_result = i_div0 ? i_rem : (i_sign_r ? w_rem_neg : i_rem);
            default: o_result = i_prod[WIDTH-1:0];
        endcase
    end

    assign o_status = '{
        negative: o_result[WIDTH-1],
        zero:     (o_result == '0),
        carry:    (i_op == MUL) && (|i_prod[2*WIDTH-1:WIDTH]),
        overflow: i_div0 || i_ovf_min
    };

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier is zero.
module mul_div_unit
    import ablomm_cpu::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             r_state, w_state_next;
    muldiv_op_e         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_q, r_sign_r, r_div0, r_ovf_min;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_status;

    muldiv_op_e         w_op_in;
    logic               w_accept, w_in_div, w_in_signed, w_in_div0, w_in_ovf_min;
    logic               w_last, w_mul_done, w_qbit;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_a_op, w_b_op;
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic [WIDTH-1:0]   w_fix_result;
    status_t            w_fix_status;

    assign w_op_in      = muldiv_op_e'(op);
    assign w_in_div     = is_div_op(w_op_in);
    assign w_in_signed  = is_signed_op(w_op_in);
    assign w_in_div0    = w_in_div && (b == '0);
    assign w_in_ovf_min = ((w_op_in == DIVS) || (w_op_in == REMS))
                          && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    assign w_a_abs      = a[WIDTH-1] ? -a : a;
    assign w_b_abs      = b[WIDTH-1] ? -b : b;
    assign w_a_op       = w_in_signed ? w_a_abs : a;
    assign w_b_op       = w_in_signed ? w_b_abs : b;
    assign w_accept     = (r_state == S_IDLE) && in_valid && !abort;

    // Divide reuses the multiply registers: r_acc low half is the remainder,
    // r_mcand low half the divisor, r_mplier shifts dividend out / quotient in.
    assign w_rem_sh = {r_acc[WIDTH-1:0], r_mplier[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_qbit   = ~w_diff[WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_done = !is_div_op(r_op) && (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_mul_done = 1'b0;
`endif
    assign w_last = (r_cnt == CNT_W'(1)) || w_mul_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_in_div0 ? S_FIXUP : S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_FIXUP;
            S_FIXUP: w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= MUL;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf_min <= 1'b0;
        end else if (w_accept) begin
            r_op      <= w_op_in;
            r_sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r  <= a[WIDTH-1];
            r_cnt     <= CNT_W'(WIDTH);
            r_div0    <= w_in_div0;
            r_ovf_min <= w_in_ovf_min;
            if (w_in_div) begin
                r_acc    <= {{WIDTH{1'b0}}, (w_in_div0 ? a : {WIDTH{1'b0}})};
                r_mcand  <= {{WIDTH{1'b0}}, w_b_op};
                r_mplier <= w_a_op;
            end else begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_a_op};
                r_mplier <= w_b_op;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (is_div_op(r_op)) begin
                r_acc[WIDTH-1:0] <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                r_mplier         <= {r_mplier[WIDTH-2:0], w_qbit};
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

    mul_div_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .i_op      (r_op),
        .i_prod    (r_acc),
        .i_quo     (r_mplier),
        .i_rem     (r_acc[WIDTH-1:0]),
        .i_sign_q  (r_sign_q),
        .i_sign_r  (r_sign_r),
        .i_div0    (r_div0),
        .i_ovf_min (r_ovf_min),
        .o_result  (w_fix_result),
        .o_status  (w_fix_status)
    );

    // An abort during FIXUP leaves the previously delivered result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_status <= '0;
        end else if ((r_state == S_FIXUP) && !abort) begin
            r_result <= w_fix_result;
            r_status <= w_fix_status;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign status    = r_status;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=8 with hand-computed results, flags and latencies.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module tb_mul_div_unit;
    import ablomm_cpu::*;

    localparam int W = 8;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int L_B0  = 2;
    localparam int L_B3  = 3;
    localparam int L_B5  = 4;
    localparam int L_B80 = 9;
    localparam int L_BFF = 9;
`else
    localparam int L_B0  = 9;
    localparam int L_B3  = 9;
    localparam int L_B5  = 9;
    localparam int L_B80 = 9;
    localparam int L_BFF = 9;
`endif
    localparam int L_DIV  = 9;
    localparam int L_DIV0 = 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   status;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    mul_div_unit #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        wait_ready();
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] exp_res,
                       input logic [3:0] exp_st, input int exp_lat);
        int lat;
        logic [W-1:0] e;
        exp_q.push_back(exp_res);
        issue(o, aa, bb);
        wait_done(lat);
        e = exp_q.pop_front();
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(result), 32'(e));
        check({tag, "_st"}, 32'(status), 32'(exp_st));
        last_res = e;
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        last_res  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // status order {negative, zero, carry, overflow}
        run("mul_200x3",     MUL,   8'd200, 8'd3,  8'h58, 4'b0010, L_B3);
        run("mulhs_fdx5",    MULHS, 8'hFD,  8'd5,  8'hFF, 4'b1000, L_B5);
        run("mulhu_fdx5",    MULHU, 8'hFD,  8'd5,  8'h04, 4'b0000, L_B5);
        run("mul_7x0",       MUL,   8'd7,   8'd0,  8'h00, 4'b0100, L_B0);
        run("mulhs_80x80",   MULHS, 8'h80,  8'h80, 8'h40, 4'b0000, L_B80);
        run("divs_f9_2",     DIVS,  8'hF9,  8'd2,  8'hFD, 4'b1000, L_DIV);
        run("rems_f9_2",     REMS,  8'hF9,  8'd2,  8'hFF, 4'b1000, L_DIV);
        run("divu_f9_2",     DIVU,  8'hF9,  8'd2,  8'h7C, 4'b0000, L_DIV);
        run("divu_200_7",    DIVU,  8'd200, 8'd7,  8'h1C, 4'b0000, L_DIV);
        run("remu_200_7",    REMU,  8'd200, 8'd7,  8'h04, 4'b0000, L_DIV);
        run("divu_10_0",     DIVU,  8'h10,  8'd0,  8'hFF, 4'b1001, L_DIV0);
        run("divs_10_0",     DIVS,  8'h10,  8'd0,  8'hFF, 4'b1001, L_DIV0);
        run("remu_25_0",     REMU,  8'h25,  8'd0,  8'h25, 4'b0001, L_DIV0);
        run("rems_f0_0",     REMS,  8'hF0,  8'd0,  8'hF0, 4'b1001, L_DIV0);
        run("divs_min_m1",   DIVS,  8'h80,  8'hFF, 8'h80, 4'b1001, L_DIV);
        run("rems_min_m1",   REMS,  8'h80,  8'hFF, 8'h00, 4'b0101, L_DIV);
        run("mul_3x5",       MUL,   8'd3,   8'd5,  8'h0F, 4'b0000, L_B5);

        // backpressure: result held, nothing accepted while DONE
        out_ready = 1'b0;
        issue(MUL, 8'd200, 8'd3);
        wait_done(lat);
        check("bp_lat", 32'(lat), 32'(L_B3));
        in_valid = 1'b1;
        op       = DIVU;
        a        = 8'd1;
        b        = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result", 32'(result), 32'h58);
            check("bp_status", 32'(status), 32'b0010);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_no_accept_busy", 32'(busy), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        last_res = 8'h58;

        // abort in the third BUSY cycle
        issue(MUL, 8'h09, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_was_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'(last_res));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // abort in IDLE with in_valid: nothing accepted
        in_valid = 1'b1;
        abort    = 1'b1;
        op       = MUL;
        a        = 8'd2;
        b        = 8'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);

        // abort in DONE with out_ready
        out_ready = 1'b0;
        issue(DIVU, 8'd200, 8'd7);
        wait_done(lat);
        check("abort_done_res", 32'(result), 32'h1C);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done_valid", 32'(out_valid), 32'd0);
        check("abort_done_ready", 32'(in_ready), 32'd1);
        check("abort_done_keep", 32'(result), 32'h1C);

        // reset mid-BUSY
        issue(DIVU, 8'd200, 8'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_status", 32'(status), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("post_rst_mul", MUL, 8'd3, 8'd5, 8'h0F, 4'b0000, L_B5);
        run("post_rst_rems", REMS, 8'd7, 8'hFE, 8'h01, 4'b0000, L_DIV);
        run("mul_ffxff", MUL, 8'hFF, 8'hFF, 8'h01, 4'b0010, L_BFF);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
